// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding,
// the default operand width and the bit-counter width helper.
package serial_sub_pkg;

    // Default operand/result width in bits (legal range 2..32).
    localparam int SERIAL_SUB_WIDTH_DEFAULT = 8;

    // Frame-level FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sub_state_e;

    // Width of a counter able to hold the values 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/half_subtractor_cell.sv
// One-bit subtractor cell: d = a - b - brw_in, with the borrow out of this bit.
// Purely combinational; the serial subtractor feeds it one bit pair per accepted cycle.
module half_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic brw_in,
    output logic d,
    output logic brw_out
);

    assign d       = a ^ b ^ brw_in;
    assign brw_out = (~a & b) | (~(a ^ b) & brw_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: accepts minuend/subtrahend bits LSB first through a
// valid/ready handshake and presents diff = a - b (mod 2^WIDTH), the final
// borrow and, optionally, a signed-overflow flag through a second handshake.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the ovf output and its logic.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);

    sub_state_e              state_q;
    sub_state_e              state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    brw_q;
    logic [WIDTH-1:0]        shreg_q;
    logic [WIDTH-1:0]        shreg_d;
    logic [WIDTH-1:0]        diff_q;
    logic                    borrow_q;

    logic                    in_ready_s;
    logic                    out_valid_s;
    logic                    accept_s;
    logic                    last_s;
    logic                    brw_in_s;
    logic                    d_s;
    logic                    brw_out_s;

    // Bit arithmetic for the pair currently on the inputs.
    half_subtractor_cell u_cell (
        .a       (a_bit),
        .b       (b_bit),
        .brw_in  (brw_in_s),
        .d       (d_s),
        .brw_out (brw_out_s)
    );

    assign accept_s = in_valid & in_ready_s;
    assign last_s   = accept_s && (state_q == ST_SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

    // Borrow entering the cell: zero for the first bit of each frame.
    always_comb begin
        brw_in_s = 1'b0;
        if (state_q == ST_SHIFT) begin
            brw_in_s = brw_q;
        end else begin
            brw_in_s = 1'b0;
        end
    end

    // Right shift with the new difference bit entering at the MSB.
    always_comb begin
        shreg_d = WIDTH'({d_s, shreg_q} >> 1);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_valid_s && out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the state register only.
    always_comb begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            ST_SHIFT: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            ST_DONE: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Bit-count next value: 1 on a frame's first bit, +1 per later bit, cleared on result hand-off.
    always_comb begin
        cnt_d = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_SHIFT: begin
                if (accept_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    cnt_d = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Bit counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Running borrow and partial-difference shift register, advanced per accepted bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            brw_q   <= 1'b0;
            shreg_q <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            brw_q   <= brw_out_s;
            shreg_q <= shreg_d;
        end else begin
            brw_q   <= brw_q;
            shreg_q <= shreg_q;
        end
    end

    // Result registers: loaded with the last bit of a frame, held otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            diff_q   <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
        end else if (last_s) begin
            diff_q   <= shreg_d;
            borrow_q <= brw_out_s;
        end else begin
            diff_q   <= diff_q;
            borrow_q <= borrow_q;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q;

    // Signed overflow: the borrow into the sign bit differs from the borrow out of it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
        end else if (last_s) begin
            ovf_q <= brw_in_s ^ brw_out_s;
        end else begin
            ovf_q <= ovf_q;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_s;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8). A frame-level model
// collects accepted bit pairs and computes the expected result with plain
// arithmetic; a negedge compare process checks every output every cycle.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk       = 1'b0;
    logic         rstn      = 1'b0;
    logic         in_valid  = 1'b0;
    logic         a_bit     = 1'b0;
    logic         b_bit     = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_bit      (a_bit),
        .b_bit      (b_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_bits    = 0;
    bit           m_pending = 1'b0;
    logic [W-1:0] m_a       = '0;
    logic [W-1:0] m_b       = '0;
    logic [W-1:0] m_diff    = '0;
    logic         m_borrow  = 1'b0;
    logic         m_ovf     = 1'b0;
    int           m_sdiff;

    // Compare, then advance the model by what the next rising edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_in_ready", 32'(in_ready), 32'd1);
                check("rst_diff", 32'(diff), 32'd0);
                check("rst_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
                check("rst_ovf", 32'(ovf), 32'd0);
`endif
                m_bits    = 0;
                m_pending = 1'b0;
                m_diff    = '0;
                m_borrow  = 1'b0;
                m_ovf     = 1'b0;
            end else begin
                check("out_valid", 32'(out_valid), 32'(m_pending));
                check("in_ready", 32'(in_ready), 32'(!m_pending));
                check("diff", 32'(diff), 32'(m_diff));
                check("borrow_out", 32'(borrow_out), 32'(m_borrow));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(m_ovf));
`endif
                if (m_pending) begin
                    if (out_ready) m_pending = 1'b0;
                end else if (in_valid) begin
                    m_a[m_bits] = a_bit;
                    m_b[m_bits] = b_bit;
                    m_bits++;
                    if (m_bits == W) begin
                        m_diff    = m_a - m_b;
                        m_borrow  = (m_a < m_b);
                        m_sdiff   = int'($signed(m_a)) - int'($signed(m_b));
                        m_ovf     = (m_sdiff > 127) || (m_sdiff < -128);
                        m_pending = 1'b1;
                        m_bits    = 0;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input bit gaps);
        for (int i = 0; i < W; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    a_bit    = 1'($urandom);
                    b_bit    = 1'($urandom);
                    step();
                end
            end
            in_valid = 1'b1;
            a_bit    = a[i];
            b_bit    = b[i];
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_frame(input string name, input logic [W-1:0] ed, input logic eb,
                                input logic eo, input bit chk_ovf, input int hold);
        int t;
        // Result must be visible right after the edge that took the last bit.
        check({name, "_latency"}, 32'(out_valid), 32'd1);
        t = 0;
        while (!out_valid && t < 20) begin
            step();
            t++;
        end
        check({name, "_diff"}, 32'(diff), 32'(ed));
        check({name, "_borrow"}, 32'(borrow_out), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        if (chk_ovf) check({name, "_ovf"}, 32'(ovf), 32'(eo));
`endif
        repeat (hold) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            a_bit     = 1'($urandom);
            b_bit     = 1'($urandom);
            step();
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_ready"}, 32'(in_ready), 32'd0);
            check({name, "_hold_diff"}, 32'(diff), 32'(ed));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({name, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rstn = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        step();

        send_frame(8'h05, 8'h03, 1'b0);
        finish_frame("f05_03", 8'h02, 1'b0, 1'b0, 1'b1, 0);

        send_frame(8'h03, 8'h05, 1'b0);
        finish_frame("f03_05", 8'hFE, 1'b1, 1'b0, 1'b1, 1);

        send_frame(8'h80, 8'h01, 1'b0);
        finish_frame("f80_01", 8'h7F, 1'b0, 1'b1, 1'b1, 0);

        send_frame(8'hC3, 8'h11, 1'b0);
        finish_frame("hold5", 8'hB2, 1'b0, 1'b0, 1'b1, 5);

        // Abort after four bits; the partial frame must vanish.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a_bit    = 1'($urandom);
            b_bit    = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        rstn     = 1'b0;
        step();
        rstn = 1'b1;
        repeat (3) begin
            step();
            check("abort_no_result", 32'(out_valid), 32'd0);
        end
        send_frame(8'hFF, 8'hFF, 1'b0);
        finish_frame("fFF_FF", 8'h00, 1'b0, 1'b0, 1'b1, 0);

        // Reset while a result is pending.
        send_frame(8'h12, 8'h34, 1'b0);
        check("pend_valid", 32'(out_valid), 32'd1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        check("pend_dropped", 32'(out_valid), 32'd0);
        check("pend_diff_clr", 32'(diff), 32'd0);

        send_frame(8'hA5, 8'h5A, 1'b0);
        finish_frame("fA5_5A", 8'h4B, 1'b0, 1'b1, 1'b1, 0);
        send_frame(8'hA5, 8'h5A, 1'b1);
        finish_frame("fA5_5A_gaps", 8'h4B, 1'b0, 1'b1, 1'b1, 2);

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            send_frame(ra, rb, 1'($urandom));
            finish_frame("rand", ra - rb, (ra < rb), 1'b0, 1'b0, $urandom_range(0, 3));
        end

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
